// File: rtl/onehot_enc_pkg.sv
// Shared types and the combinational 8-to-3 encode rule for the one-hot encoder stream.
// The encode result carries the index plus flags for all-zero and multi-hot source vectors.
package onehot_enc_pkg;

  localparam int VEC_W = 8;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             zero;
    logic             multi;
  } enc_entry_t;

  // Highest set bit wins, so a malformed vector still reports a usable index.
  function automatic enc_entry_t encode_vec(input logic [VEC_W-1:0] vec);
    enc_entry_t entry;
    logic       seen;
    entry = '0;
    seen  = 1'b0;
    for (int i = 0; i < VEC_W; i++) begin
      if (vec[i]) begin
        entry.idx = IDX_W'(i);
        if (seen) begin
          entry.multi = 1'b1;
        end
        seen = 1'b1;
      end
    end
    entry.zero = ~seen;
    return entry;
  endfunction

endpackage

// File: rtl/onehot_enc_fifo.sv
// Synchronous FIFO of encoder results; a separate count tells full from empty since
// the pointers wrap modulo DEPTH and can be equal in both states.
module onehot_enc_fifo
  import onehot_enc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  enc_entry_t data_i,
  output enc_entry_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  enc_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  // Blank the head when empty so the output bus reads zero after reset.
  assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
    end
    if (doPop) begin
      rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/onehot_encoder_stream.sv
// Streaming 8-to-3 encoder: encodes accepted vectors, queues results in a small FIFO
// and keeps a saturating count of malformed (zero or multi-hot) inputs.
module onehot_encoder_stream #(
  parameter int VEC_W     = onehot_enc_pkg::VEC_W,
  parameter int IDX_W     = onehot_enc_pkg::IDX_W,
  parameter int DEPTH     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [VEC_W-1:0]     in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_zero,
  output logic                 out_multi,
  output logic [ERR_CNT_W-1:0] err_count
);

  import onehot_enc_pkg::*;

  enc_entry_t           encEntry;
  enc_entry_t           headEntry;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 push;
  logic                 pop;
  logic [ERR_CNT_W-1:0] errCount_q, errCount_d;

  assign encEntry  = encode_vec(in_vec);
  assign in_ready  = ~fifoFull;
  assign out_valid = ~fifoEmpty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_idx   = headEntry.idx;
  assign out_zero  = headEntry.zero;
  assign out_multi = headEntry.multi;
  assign err_count = errCount_q;

  onehot_enc_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .data_i (encEntry),
    .data_o (headEntry),
    .full_o (fifoFull),
    .empty_o(fifoEmpty)
  );

  // Errors are counted at accept time and stick at all-ones rather than wrapping.
  always_comb begin
    errCount_d = errCount_q;
    if (push && (encEntry.zero || encEntry.multi) && (errCount_q != '1)) begin
      errCount_d = errCount_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      errCount_q <= '0;
    end else begin
      errCount_q <= errCount_d;
    end
  end

endmodule

// File: tb/tb_onehot_encoder_stream.sv
// Directed bench for onehot_encoder_stream: vector table plus hand-written corner sequences.
module tb_onehot_encoder_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_zero;
  logic       out_multi;
  logic [7:0] err_count;

  logic       satValid;
  logic       satReady;
  logic [7:0] satVec;
  logic       satInReady;
  logic       satOutValid;
  logic [2:0] satIdx;
  logic       satZero;
  logic       satMulti;
  logic [1:0] satErr;

  int compared = 0;
  int mismatched = 0;
  int expErr = 0;

  typedef struct {
    logic [7:0] vec;
    logic [2:0] idx;
    logic       zero;
    logic       multi;
  } vector_t;

  vector_t vectors [12];

  always #5 clk = ~clk;

  onehot_encoder_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_zero (out_zero),
    .out_multi(out_multi),
    .err_count(err_count)
  );

  onehot_encoder_stream #(.ERR_CNT_W(2)) dutSat (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (satValid),
    .in_ready (satInReady),
    .in_vec   (satVec),
    .out_valid(satOutValid),
    .out_ready(satReady),
    .out_idx  (satIdx),
    .out_zero (satZero),
    .out_multi(satMulti),
    .err_count(satErr)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive inputs, let one rising edge pass, then settle before the caller samples.
  task automatic applyStimulus(input logic valid, input logic [7:0] vec, input logic ready);
    in_valid  = valid;
    in_vec    = vec;
    out_ready = ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors[0]  = '{8'h01, 3'd0, 1'b0, 1'b0};
    vectors[1]  = '{8'h02, 3'd1, 1'b0, 1'b0};
    vectors[2]  = '{8'h04, 3'd2, 1'b0, 1'b0};
    vectors[3]  = '{8'h08, 3'd3, 1'b0, 1'b0};
    vectors[4]  = '{8'h10, 3'd4, 1'b0, 1'b0};
    vectors[5]  = '{8'h20, 3'd5, 1'b0, 1'b0};
    vectors[6]  = '{8'h40, 3'd6, 1'b0, 1'b0};
    vectors[7]  = '{8'h80, 3'd7, 1'b0, 1'b0};
    vectors[8]  = '{8'h00, 3'd0, 1'b1, 1'b0};
    vectors[9]  = '{8'h81, 3'd7, 1'b0, 1'b1};
    vectors[10] = '{8'hFF, 3'd7, 1'b0, 1'b1};
    vectors[11] = '{8'h06, 3'd2, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 8'h01;
    out_ready = 1'b1;
    satValid  = 1'b0;
    satVec    = 8'h00;
    satReady  = 1'b1;

    // Reset held two edges with a valid input present.
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset err_count", err_count, 0);
    checkOutput("reset out_idx", out_idx, 0);
    checkOutput("reset out_zero", out_zero, 0);
    checkOutput("reset out_multi", out_multi, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("post-reset nothing emerges", out_valid, 0);

    // Back-to-back stream with the consumer always ready.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vectors[i].vec, 1'b1);
      if (vectors[i].zero || vectors[i].multi) expErr++;
      checkOutput($sformatf("vec%0d out_valid", i), out_valid, 1);
      checkOutput($sformatf("vec%0d out_idx", i), out_idx, vectors[i].idx);
      checkOutput($sformatf("vec%0d out_zero", i), out_zero, vectors[i].zero);
      checkOutput($sformatf("vec%0d out_multi", i), out_multi, vectors[i].multi);
      checkOutput($sformatf("vec%0d in_ready", i), in_ready, 1);
      checkOutput($sformatf("vec%0d err_count", i), err_count, expErr);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("stream drained", out_valid, 0);

    // Backpressure: two entries fill the FIFO, third waits.
    applyStimulus(1'b1, 8'h04, 1'b0);
    checkOutput("bp first idx", out_idx, 2);
    applyStimulus(1'b1, 8'h10, 1'b0);
    checkOutput("bp full in_ready", in_ready, 0);
    checkOutput("bp head held", out_idx, 2);
    applyStimulus(1'b1, 8'h40, 1'b0);
    checkOutput("bp third blocked", in_ready, 0);
    checkOutput("bp head stable", out_idx, 2);
    checkOutput("bp out_valid held", out_valid, 1);
    applyStimulus(1'b1, 8'h40, 1'b1);
    checkOutput("bp second out", out_idx, 4);
    checkOutput("bp space freed", in_ready, 1);
    applyStimulus(1'b1, 8'h40, 1'b1);
    checkOutput("bp third out", out_idx, 6);
    checkOutput("bp third valid", out_valid, 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("bp drained", out_valid, 0);

    // Simultaneous push and pop with one entry queued.
    applyStimulus(1'b1, 8'h01, 1'b0);
    checkOutput("pp first idx", out_idx, 0);
    applyStimulus(1'b1, 8'h80, 1'b1);
    checkOutput("pp head advanced", out_idx, 7);
    checkOutput("pp count stays 1", in_ready, 1);
    checkOutput("pp still valid", out_valid, 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pp drained", out_valid, 0);
    checkOutput("err_count after bp/pp", err_count, expErr);

    // Reset with a full FIFO and an input in flight.
    applyStimulus(1'b1, 8'h08, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput("mid full", in_ready, 0);
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h01, 1'b0);
    checkOutput("mid reset out_valid", out_valid, 0);
    checkOutput("mid reset in_ready", in_ready, 1);
    checkOutput("mid reset err_count", err_count, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("mid reset data lost", out_valid, 0);

    // Saturation on the 2-bit error counter instance.
    satValid = 1'b1;
    satVec   = 8'h00;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("sat step%0d", k), satErr, (k < 3) ? k + 1 : 3);
    end
    satValid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
